// File: rtl/big_arith_pkg.sv
// -----------------------------------------------------------------------------
// big_arith_pkg
//   Shared types and constants for the big-integer datapath blocks.
//   LIMB_W      : default limb width in bits
//   limb_t      : one limb of an operand
//   sub_state_t : control states of the limb-serial subtractor
// -----------------------------------------------------------------------------
package big_arith_pkg;

   localparam int unsigned LIMB_W = 16;

   typedef logic [LIMB_W-1:0] limb_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage

// File: rtl/big_sub_serial_limb_sub.sv
// -----------------------------------------------------------------------------
// limb_sub
//   Combinational single-limb subtractor with borrow in/out.
//   Ports:
//     a    in  W  minuend limb
//     b    in  W  subtrahend limb
//     bin  in  1  borrow from the next-lower limb
//     d    out W  difference limb, a - b - bin mod 2^W
//     bout out 1  borrow into the next-higher limb
// -----------------------------------------------------------------------------
module limb_sub
   import big_arith_pkg::*;
#(
   parameter int unsigned W = LIMB_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   logic [W:0] t;

   // One extra bit catches the borrow as the sign of the widened result.
   always_comb begin
      t    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      d    = t[W-1:0];
      bout = t[W];
   end

endmodule

// File: rtl/big_sub_serial.sv
// -----------------------------------------------------------------------------
// big_sub_serial
//   Limb-serial WIDTH-bit subtractor: diff = x - y mod 2^WIDTH, one LIMB_W
//   limb per cycle, least-significant limb first, ripple borrow between cycles.
//   Operands accepted at edge k produce out_valid after edge k+NLIMB.
//
//   Optional feature macro: BIG_SUB_SELF_CHECK_EN
//     defined   : nok flags a mismatch between the serial result and a native
//                 (WIDTH+1)-bit subtraction, valid alongside out_valid
//     undefined : nok is constant 0 and no wide subtractor exists
//
//   Ports:
//     clk        in   1      clock, all state on posedge
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      x, y valid
//     in_ready   out  1      operands can be accepted (IDLE only)
//     x          in   WIDTH  minuend
//     y          in   WIDTH  subtrahend
//     out_valid  out  1      diff/borrow/nok valid
//     out_ready  in   1      consumer takes the result
//     diff       out  WIDTH  x - y mod 2^WIDTH
//     borrow     out  1      1 iff x < y (unsigned)
//     nok        out  1      self-check mismatch flag
// -----------------------------------------------------------------------------
module big_sub_serial
   import big_arith_pkg::*;
#(
   parameter int unsigned WIDTH  = 256,
   parameter int unsigned LIMB_W = big_arith_pkg::LIMB_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             nok
);

   localparam int unsigned NLIMB = WIDTH / LIMB_W;
   localparam int unsigned IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NLIMB - 1);

   sub_state_t                   state;
   logic [NLIMB-1:0][LIMB_W-1:0] x_q;
   logic [NLIMB-1:0][LIMB_W-1:0] y_q;
   logic [NLIMB-1:0][LIMB_W-1:0] diff_q;
   logic [IDX_W-1:0]             idx;
   logic                         b_q;

   logic [LIMB_W-1:0]            d_limb;
   logic                         bout;

   // Single limb subtractor shared across all limbs, steered by idx.
   limb_sub #(
      .W (LIMB_W)
   ) u_limb_sub (
      .a    (x_q[idx]),
      .b    (y_q[idx]),
      .bin  (b_q),
      .d    (d_limb),
      .bout (bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff_q    <= '0;
         b_q       <= 1'b0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_q      <= x;
                  y_q      <= y;
                  idx      <= '0;
                  b_q      <= 1'b0;
                  diff_q   <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               diff_q[idx] <= d_limb;
               b_q         <= bout;
               // idx parks on the last limb instead of wrapping.
               if (idx == IDX_LAST) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               // in_ready rises only after the handshake edge, never with it.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign diff   = diff_q;
   assign borrow = b_q;

`ifdef BIG_SUB_SELF_CHECK_EN
   logic [NLIMB-1:0][LIMB_W-1:0] diff_next;
   logic                         nok_q;

   // Result as it will be after the final RUN edge, so the compare lines up
   // with out_valid rising.
   always_comb begin
      diff_next      = diff_q;
      diff_next[idx] = d_limb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nok_q <= 1'b0;
      end else if (state == RUN && idx == IDX_LAST) begin
         nok_q <= ({bout, diff_next} != ({1'b0, x_q} - {1'b0, y_q}));
      end else if (state == DONE && out_ready) begin
         nok_q <= 1'b0;
      end
   end

   assign nok = nok_q;
`else
   assign nok = 1'b0;
`endif

endmodule

// File: tb/tb_big_sub_serial.sv
module tb_big_sub_serial;

   localparam int unsigned WIDTH  = 256;
   localparam int unsigned LIMB_W = 16;
   localparam int unsigned NLIMB  = WIDTH / LIMB_W;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             nok;

   big_sub_serial #(
      .WIDTH  (WIDTH),
      .LIMB_W (LIMB_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .nok       (nok)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             b;
   } exp_t;

   exp_t sb[$];
   int   n_vec    = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   bit   ov_prev  = 1'b0;
   bit   last_acc = 1'b0;

   task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_op();
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock: score the output handshake and note the input handshake
   // using values present before the edge, then advance to #1 past the edge.
   task automatic step();
      logic             acc;
      logic             hs;
      logic [WIDTH-1:0] xs;
      logic [WIDTH-1:0] ys;
      exp_t             e;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      xs  = x;
      ys  = y;
      if (hs) begin
         if (sb.size() == 0) begin
            check("stray_result", 1, 0);
         end else begin
            e = sb.pop_front();
            check("diff", diff, e.d);
            check("borrow", borrow, e.b);
            check("nok", nok, 0);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      last_acc = acc;
      if (acc) begin
         e.d = xs - ys;
         e.b = (xs < ys);
         sb.push_back(e);
         acc_cyc = cyc;
      end
      if (out_valid && !ov_prev) check("latency", cyc - acc_cyc, NLIMB);
      ov_prev = out_valid;
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb);
      int n = 0;
      x        = a;
      y        = bb;
      in_valid = 1'b1;
      do begin
         step();
         n++;
      end while (!last_acc && n < 50);
      if (!last_acc) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      x        = rand_op();
      y        = rand_op();
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         step();
         n++;
      end
      if (sb.size() > 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      step();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst      = 1'b1;
      repeat (3) step();
      sb.delete();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
      check("rst_nok", nok, 0);
      rst = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] hd;
      logic             hb;
      int               cnt;
      int               nacc;
      int               guard;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      y         = '0;
      do_reset();

      // Reset in the middle of an operation must drop it silently.
      out_ready = 1'b1;
      send(rand_op(), rand_op());
      repeat (5) step();
      do_reset();
      step();
      check("post_rst_in_ready", in_ready, 1);
      cnt = 0;
      repeat (30) begin
         step();
         if (out_valid) cnt++;
      end
      check("no_stray_after_rst", cnt, 0);

      // Directed corners.
      send(WIDTH'(5), WIDTH'(3));
      drain();
      send('0, WIDTH'(1));
      drain();
      a     = '0;
      a[16] = 1'b1;
      send(a, WIDTH'(1));
      drain();
      a = rand_op();
      send(a, a);
      drain();
      send('1, '1);
      drain();

      // Result held while the consumer stalls; new operands refused.
      out_ready = 1'b0;
      send(rand_op(), rand_op());
      cnt = 0;
      while (!out_valid && cnt < 50) begin
         step();
         cnt++;
      end
      check("stall_reach_done", out_valid, 1);
      hd = diff;
      hb = borrow;
      repeat (10) begin
         in_valid = 1'b1;
         x        = rand_op();
         y        = rand_op();
         step();
         check("hold_diff", diff, hd);
         check("hold_borrow", borrow, hb);
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);

      // Random back-to-back traffic with random consumer back-pressure.
      nacc     = 0;
      guard    = 0;
      x        = rand_op();
      y        = rand_op();
      in_valid = 1'b1;
      while ((nacc < 1000 || sb.size() > 0) && guard < 60000) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
         guard++;
         if (last_acc) begin
            nacc++;
            x = rand_op();
            y = ($urandom_range(0, 15) == 0) ? x : rand_op();
            if (nacc >= 1000) in_valid = 1'b0;
         end
      end
      if (guard >= 60000) check("random_timeout", 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
